// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: stall merge, multi-cycle op sequencing, exception flush, stall counter.
// Stall/done/abort are combinational this cycle; flush/new_pc/mc_busy register one cycle after the request.
module pipe_hazard_ctrl #(
    parameter int STAGES   = 6,
    parameter int PC_W     = 32,
    parameter int MC_STAGE = 3,
    parameter int MC_LAT   = 32,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req,
    input  logic              mc_start,
    input  logic              excp_req,
    input  logic [PC_W-1:0]   excp_pc,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc,
    output logic              mc_busy,
    output logic              mc_done,
    output logic              mc_abort,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [7:0] LP_MC_LOAD = 8'(MC_LAT - 1);

    state_t             r_state;
    logic [7:0]         r_mc_cnt;
    logic               r_flush;
    logic               r_mc_busy;
    logic [PC_W-1:0]    r_new_pc;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic [STAGES-1:0]  w_eff_req;
    logic [STAGES-1:0]  w_stall;
    logic               w_acc;
    logic               w_in_mc;
    logic               w_mc_last;

    assign w_in_mc   = (r_state == ST_MC_BUSY);
    assign w_mc_last = w_in_mc && (r_mc_cnt == 8'd0);

    // A stalled stage must also hold every stage upstream of it: suffix-OR from the top.
    always_comb begin
        w_eff_req = stall_req;
        if (w_in_mc) begin
            w_eff_req[MC_STAGE] = 1'b1;
        end
        w_acc   = 1'b0;
        w_stall = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_acc      = w_acc | w_eff_req[i];
            w_stall[i] = w_acc;
        end
        if (rst || (r_state == ST_FLUSH)) begin
            w_stall = '0;
        end
    end

    assign stall        = w_stall;
    assign mc_done      = !rst && w_mc_last && !excp_req;
    assign mc_abort     = !rst && w_in_mc && excp_req;
    assign flush        = r_flush;
    assign new_pc       = r_new_pc;
    assign mc_busy      = r_mc_busy;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_mc_cnt       <= 8'd0;
            r_flush        <= 1'b0;
            r_mc_busy      <= 1'b0;
            r_new_pc       <= '0;
            r_stall_cycles <= '0;
        end else begin
            if ((w_stall != '0) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    // Exception takes priority; a co-issued multi-cycle op is silently dropped.
                    if (excp_req) begin
                        r_state  <= ST_FLUSH;
                        r_flush  <= 1'b1;
                        r_new_pc <= excp_pc;
                    end else if (mc_start) begin
                        r_state   <= ST_MC_BUSY;
                        r_mc_busy <= 1'b1;
                        r_mc_cnt  <= LP_MC_LOAD;
                    end
                end
                ST_MC_BUSY: begin
                    if (excp_req) begin
                        r_state   <= ST_FLUSH;
                        r_flush   <= 1'b1;
                        r_new_pc  <= excp_pc;
                        r_mc_busy <= 1'b0;
                        r_mc_cnt  <= 8'd0;
                    end else if (r_mc_cnt == 8'd0) begin
                        r_state   <= ST_IDLE;
                        r_mc_busy <= 1'b0;
                    end else begin
                        r_mc_cnt <= r_mc_cnt - 8'd1;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_flush   <= 1'b0;
                    r_mc_busy <= 1'b0;
                    r_mc_cnt  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, corner sequences and random traffic
// on two instances (MC_LAT=4/CNT_W=4 and MC_LAT=1/CNT_W=8) checked against a cycle model.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_req;
    logic        mc_start;
    logic        excp_req;
    logic [31:0] excp_pc;

    logic [5:0]  stall_a,  stall_b;
    logic        flush_a,  flush_b;
    logic [31:0] new_pc_a, new_pc_b;
    logic        busy_a,   busy_b;
    logic        done_a,   done_b;
    logic        abort_a,  abort_b;
    logic [3:0]  cnt_a;
    logic [7:0]  cnt_b;

    int n_err = 0;
    int n_chk = 0;
    bit armed = 0;

    pipe_hazard_ctrl #(.STAGES(6), .PC_W(32), .MC_STAGE(3), .MC_LAT(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .stall_req(stall_req), .mc_start(mc_start),
        .excp_req(excp_req), .excp_pc(excp_pc), .stall(stall_a), .flush(flush_a),
        .new_pc(new_pc_a), .mc_busy(busy_a), .mc_done(done_a), .mc_abort(abort_a),
        .stall_cycles(cnt_a));

    pipe_hazard_ctrl #(.STAGES(6), .PC_W(32), .MC_STAGE(3), .MC_LAT(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .stall_req(stall_req), .mc_start(mc_start),
        .excp_req(excp_req), .excp_pc(excp_pc), .stall(stall_b), .flush(flush_b),
        .new_pc(new_pc_b), .mc_busy(busy_b), .mc_done(done_b), .mc_abort(abort_b),
        .stall_cycles(cnt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: busy cycles remaining, pending flush, captured pc, stall count.
    int unsigned     m_rem [2];
    bit              m_pend[2];
    logic [31:0]     m_pc  [2];
    longint unsigned m_cnt [2];

    task automatic model(input int d, input bit do_chk,
                         input logic [5:0] a_stall, input logic a_flush, input logic [31:0] a_pc,
                         input logic a_busy, input logic a_done, input logic a_abort,
                         input logic [63:0] a_cnt);
        int unsigned     lat  = (d == 0) ? 4 : 1;
        longint unsigned cmax = (d == 0) ? 15 : 255;
        string           p    = (d == 0) ? "A" : "B";
        bit              busy = (m_rem[d] != 0);
        logic [5:0]      eff;
        logic [5:0]      e_stall;
        int              hi;
        eff = stall_req;
        if (busy) eff[3] = 1'b1;
        hi = -1;
        for (int i = 0; i < 6; i++) if (eff[i]) hi = i;
        e_stall = (rst || m_pend[d]) ? 6'd0 : 6'((1 << (hi + 1)) - 1);
        if (do_chk) begin
            chk({p, ".stall"}, 64'(a_stall), 64'(e_stall));
            chk({p, ".flush"}, 64'(a_flush), 64'(m_pend[d]));
            if (m_pend[d]) chk({p, ".new_pc"}, 64'(a_pc), 64'(m_pc[d]));
            chk({p, ".mc_busy"}, 64'(a_busy), 64'(busy));
            chk({p, ".mc_done"}, 64'(a_done), 64'(!rst && busy && m_rem[d] == 1 && !excp_req));
            chk({p, ".mc_abort"}, 64'(a_abort), 64'(!rst && busy && excp_req));
            chk({p, ".stall_cycles"}, a_cnt, 64'(m_cnt[d]));
        end
        if (rst) begin
            m_rem[d] = 0; m_pend[d] = 0; m_pc[d] = '0; m_cnt[d] = 0;
        end else begin
            if (e_stall != 0 && m_cnt[d] < cmax) m_cnt[d]++;
            if (m_pend[d]) m_pend[d] = 0;
            else if (excp_req) begin m_pend[d] = 1; m_pc[d] = excp_pc; m_rem[d] = 0; end
            else if (busy) m_rem[d]--;
            else if (mc_start) m_rem[d] = lat;
        end
    endtask

    always @(negedge clk) begin
        model(0, armed, stall_a, flush_a, new_pc_a, busy_a, done_a, abort_a, 64'(cnt_a));
        model(1, armed, stall_b, flush_b, new_pc_b, busy_b, done_b, abort_b, 64'(cnt_b));
        if (rst) armed = 1;
    end

    typedef struct {
        logic        r;
        logic [5:0]  req;
        logic        ms;
        logic        ex;
        logic [31:0] pc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic        e_busy;
        logic        e_done;
        logic        e_abort;
        logic [31:0] e_pc;
        logic [3:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(logic r, logic [5:0] req, logic ms, logic ex, logic [31:0] pc,
                                logic [5:0] es, logic ef, logic eb, logic ed, logic ea,
                                logic [31:0] ep, logic [3:0] ec);
        vec_t v;
        v.r = r; v.req = req; v.ms = ms; v.ex = ex; v.pc = pc;
        v.e_stall = es; v.e_flush = ef; v.e_busy = eb; v.e_done = ed; v.e_abort = ea;
        v.e_pc = ep; v.e_cnt = ec;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [5:0] req, input logic ms,
                         input logic ex, input logic [31:0] pc);
        rst = r; stall_req = req; mc_start = ms; excp_req = ex; excp_pc = pc;
    endtask

    vec_t tbl[27];

    initial begin
        drive(1'b1, 6'd0, 1'b0, 1'b0, 32'd0);
        //            r  req        ms ex pc            stall      fl bz dn ab e_pc          cnt
        tbl[0]  = mk(1, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd0);
        tbl[1]  = mk(1, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd0);
        tbl[2]  = mk(0, 6'b000100, 0, 0, 32'h0,        6'b000111, 0, 0, 0, 0, 32'h0,        4'd0);
        tbl[3]  = mk(0, 6'b001010, 0, 0, 32'h0,        6'b001111, 0, 0, 0, 0, 32'h0,        4'd1);
        tbl[4]  = mk(0, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd2);
        tbl[5]  = mk(0, 6'b000000, 1, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd2);
        tbl[6]  = mk(0, 6'b000000, 0, 0, 32'h0,        6'b001111, 0, 1, 0, 0, 32'h0,        4'd2);
        tbl[7]  = mk(0, 6'b000000, 1, 0, 32'h0,        6'b001111, 0, 1, 0, 0, 32'h0,        4'd3);
        tbl[8]  = mk(0, 6'b000000, 0, 0, 32'h0,        6'b001111, 0, 1, 0, 0, 32'h0,        4'd4);
        tbl[9]  = mk(0, 6'b000000, 0, 0, 32'h0,        6'b001111, 0, 1, 1, 0, 32'h0,        4'd5);
        tbl[10] = mk(0, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd6);
        tbl[11] = mk(0, 6'b000111, 0, 1, 32'hBFC00380, 6'b000111, 0, 0, 0, 0, 32'h0,        4'd6);
        tbl[12] = mk(0, 6'b000111, 0, 0, 32'h0,        6'b000000, 1, 0, 0, 0, 32'hBFC00380, 4'd7);
        tbl[13] = mk(0, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd7);
        tbl[14] = mk(0, 6'b000000, 1, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd7);
        tbl[15] = mk(0, 6'b000000, 0, 0, 32'h0,        6'b001111, 0, 1, 0, 0, 32'h0,        4'd7);
        tbl[16] = mk(0, 6'b000000, 0, 1, 32'h100,      6'b001111, 0, 1, 0, 1, 32'h0,        4'd8);
        tbl[17] = mk(0, 6'b000000, 0, 0, 32'h0,        6'b000000, 1, 0, 0, 0, 32'h100,      4'd9);
        tbl[18] = mk(0, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd9);
        tbl[19] = mk(0, 6'b000000, 1, 1, 32'h200,      6'b000000, 0, 0, 0, 0, 32'h0,        4'd9);
        tbl[20] = mk(0, 6'b000000, 0, 1, 32'h300,      6'b000000, 1, 0, 0, 0, 32'h200,      4'd9);
        tbl[21] = mk(0, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd9);
        tbl[22] = mk(0, 6'b000000, 1, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd9);
        tbl[23] = mk(0, 6'b000000, 0, 0, 32'h0,        6'b001111, 0, 1, 0, 0, 32'h0,        4'd9);
        tbl[24] = mk(1, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 1, 0, 0, 32'h0,        4'd10);
        tbl[25] = mk(0, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd0);
        tbl[26] = mk(0, 6'b000000, 0, 0, 32'h0,        6'b000000, 0, 0, 0, 0, 32'h0,        4'd0);

        @(posedge clk); #1;
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].r, tbl[i].req, tbl[i].ms, tbl[i].ex, tbl[i].pc);
            @(negedge clk);
            chk($sformatf("vec%0d.stall", i), 64'(stall_a), 64'(tbl[i].e_stall));
            chk($sformatf("vec%0d.flush", i), 64'(flush_a), 64'(tbl[i].e_flush));
            if (tbl[i].e_flush) chk($sformatf("vec%0d.new_pc", i), 64'(new_pc_a), 64'(tbl[i].e_pc));
            chk($sformatf("vec%0d.mc_busy", i), 64'(busy_a), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d.mc_done", i), 64'(done_a), 64'(tbl[i].e_done));
            chk($sformatf("vec%0d.mc_abort", i), 64'(abort_a), 64'(tbl[i].e_abort));
            chk($sformatf("vec%0d.stall_cycles", i), 64'(cnt_a), 64'(tbl[i].e_cnt));
            @(posedge clk); #1;
        end

        // Reset in the middle of a busy op: no done pulse may follow.
        drive(1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 6'd0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid.done%0d", i), 64'(done_a), 64'd0);
            chk($sformatf("rst_mid.busy%0d", i), 64'(busy_a), 64'd0);
            @(posedge clk); #1;
        end

        // Continuous stall: 4-bit counter climbs to 15 and holds.
        drive(1'b0, 6'b100000, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            chk($sformatf("sat.stall%0d", i), 64'(stall_a), 64'h3F);
            chk($sformatf("sat.cnt%0d", i), 64'(cnt_a), 64'((i < 15) ? i : 15));
            @(posedge clk); #1;
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 11) == 0),
                  $urandom);
            @(posedge clk); #1;
        end
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the in-order CPU pipeline.
- Merges per-stage stall requests into a stall vector.
- Sequences multi-cycle execute operations (divider/multiplier) with an internal latency counter.
- Registers exception/redirect requests into a one-cycle flush with a new PC.
- Keeps a saturating stall-cycle performance counter.

Parameters:
STAGES, 6, number of pipeline stages including the PC stage; stall bit i = stage i (0 = PC).
PC_W, 32, program-counter width.
MC_STAGE, 3, stage index that issues multi-cycle ops (EX).
MC_LAT, 32, cycles a multi-cycle op occupies MC_STAGE; range 1..255.
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_req  in  STAGES  bit k = stage k requests a hold this cycle
mc_start  in  1  multi-cycle op begins in MC_STAGE this cycle
excp_req  in  1  exception/redirect request
excp_pc  in  PC_W  redirect target, valid with excp_req
stall  out  STAGES  bit i = 1 holds stage i
flush  out  1  one-cycle pipeline flush (registered)
new_pc  out  PC_W  fetch target, valid while flush = 1 (registered)
mc_busy  out  1  multi-cycle op in progress
mc_done  out  1  one-cycle pulse on the last busy cycle
mc_abort  out  1  one-cycle pulse when an op is killed by an exception
stall_cycles  out  CNT_W  count of cycles with stall != 0, saturating

Behaviour:
- Reset:
  - stall = 0, flush = 0, new_pc = 0, mc_busy = 0, mc_done = 0, mc_abort = 0, stall_cycles = 0.
  - State = IDLE, latency counter = 0.
- Stall merge (combinational):
  - Let k = highest set index of the effective request vector. Then stall[k:0] = 1 and stall[STAGES-1:k+1] = 0.
  - Effective request = stall_req, plus bit MC_STAGE while state is MC_BUSY.
  - Example, STAGES = 6: request on bit 2 gives 6'b00_0111; request on bit 3 gives 6'b00_1111.
- States: IDLE, MC_BUSY, FLUSH.
- IDLE:
  - excp_req = 1: go to FLUSH. Capture excp_pc into new_pc. excp_req wins over mc_start in the same cycle; that op is dropped and mc_abort is not pulsed.
  - Else mc_start = 1: go to MC_BUSY. Load counter = MC_LAT - 1. mc_busy is registered, rising in the next cycle.
- MC_BUSY:
  - mc_busy = 1.
  - Each cycle: if counter = 0, pulse mc_done, deassert mc_busy next cycle and return to IDLE; otherwise counter decrements.
  - MC_LAT = 1 gives exactly one busy cycle with mc_done in it.
  - mc_start while busy is ignored.
  - excp_req = 1: go to FLUSH, capture excp_pc, pulse mc_abort in the same cycle. mc_done is not pulsed even if counter = 0.
- FLUSH (exactly one cycle):
  - flush = 1, new_pc = captured excp_pc, stall = all zeros (stall_req and mc are masked).
  - excp_req and mc_start in this cycle are ignored.
  - Next state IDLE; flush returns to 0. new_pc holds its value but is don't-care when flush = 0.
- Flush latency: excp_req in cycle N gives flush = 1 in cycle N+1.
- Stall during an exception cycle: stall still follows stall_req for that cycle; stalls are cleared only in FLUSH.
- stall_cycles:
  - Increments by 1 in every cycle where the stall output != 0.
  - Holds at all ones when saturated; never wraps.
  - Cleared only by rst.
- rst mid-operation (any state): everything returns to reset values next edge. No pending flush or done pulse is emitted afterwards.

Test Plan:
1. Reset check, STAGES = 6: rst high 2 cycles, all requests idle -> every output 0, stall_cycles = 0.
2. Stall merge: stall_req = 6'b000100 -> stall = 6'b000111. stall_req = 6'b001010 -> stall = 6'b001111. stall_req = 0 -> stall = 0, stall_cycles = 2.
3. Multi-cycle op, MC_LAT = 4: mc_start at cycle 10 -> mc_busy and stall = 6'b001111 in cycles 11-14, mc_done only in cycle 14, mc_busy = 0 and stall = 0 in cycle 15. A second mc_start in cycle 12 is ignored.
4. Exception, excp_pc = 0xBFC00380 in cycle 20 while stall_req = 6'b000111 -> cycle 20 stall = 6'b000111; cycle 21 flush = 1, new_pc = 0xBFC00380, stall = 0 even with stall_req held; cycle 22 flush = 0.
5. Abort: mc_start at cycle 30 (MC_LAT = 4), excp_req at cycle 32 -> mc_abort pulses in cycle 32, flush = 1 in cycle 33, no mc_done ever, mc_busy = 0 from cycle 33.
6. Simultaneous / edge cases:
   - excp_req and mc_start in the same IDLE cycle -> flush next cycle, mc_busy never set.
   - excp_req during FLUSH -> ignored.
   - rst in the middle of MC_BUSY -> no mc_done afterwards.
   - CNT_W = 4 with a continuous stall -> stall_cycles holds at 15.
